// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store datapath: MIPS store opcodes, instruction
// field bit positions, the store-width classification and small helpers.
// Build option: STORE_ALIGN_CHECK_EN (used in store.sv) enables alignment
// fault detection.
// -----------------------------------------------------------------------------
package store_pkg;

    // Store opcodes (instruction[31:26])
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SB = 6'b101000;

    // I-type instruction field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Width class of the access carried by the current instruction
    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_BYTE = 2'd1,
        ST_HALF = 2'd2,
        ST_WORD = 2'd3
    } store_kind_e;

    // Map an opcode onto its store width; anything unknown is not a store.
    function automatic store_kind_e decode_kind(input logic [5:0] opcode);
        store_kind_e kind;
        case (opcode)
            OP_SW:   kind = ST_WORD;
            OP_SH:   kind = ST_HALF;
            OP_SB:   kind = ST_BYTE;
            default: kind = ST_NONE;
        endcase
        return kind;
    endfunction

    // Sign-extend a 16-bit immediate to 32 bits.
    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/store_agu.sv
// -----------------------------------------------------------------------------
// store_agu
// Address generation unit: effective address = base + sign-extended imm,
// wrapping modulo 2^32 (no overflow detection). Purely combinational; the
// result is registered by the parent.
// Ports:
//   base    in  32  register-file value of rs
//   imm     in  16  instruction immediate
//   ea      out 32  effective byte address
// -----------------------------------------------------------------------------
module store_agu
    import store_pkg::*;
(
    input  logic [31:0] base,
    input  logic [15:0] imm,
    output logic [31:0] ea
);

    logic [31:0] imm_ext_s;

    // Sign extension of the displacement
    always_comb begin
        imm_ext_s = sign_ext16(imm);
    end

    // Wrapping 32-bit add; carry-out intentionally discarded
    always_comb begin
        ea = base + imm_ext_s;
    end

endmodule

// File: rtl/store.sv
// -----------------------------------------------------------------------------
// store
// Store unit for a MIPS-style pipeline. Every cycle it samples an I-type
// instruction with its rs/rt register values, computes the effective address,
// and presents a registered memory write (address, lane-replicated data,
// little-endian byte enables, write strobe) one cycle later.
// Build option: define STORE_ALIGN_CHECK_EN to suppress misaligned SH/SW
// writes and flag them on 'misaligned'; otherwise 'misaligned' is always 0 and
// the offending low address bits are ignored.
// Ports:
//   clk           in  1   rising-edge clock
//   reset         in  1   synchronous active-high reset
//   instruction   in  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:0] imm
//   Read_data1    in  32  rs value (base)
//   Read_data2    in  32  rt value (store data)
//   address       out 32  registered effective byte address
//   write_enable  out 1   registered write strobe
//   write_data    out 32  registered lane-aligned data
//   byte_en       out 4   registered byte enables (bit i -> data[8i+7:8i])
//   misaligned    out 1   registered alignment fault flag
// -----------------------------------------------------------------------------
module store
    import store_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] Read_data1,
    input  logic [31:0] Read_data2,
    output logic [31:0] address,
    output logic        write_enable,
    output logic [31:0] write_data,
    output logic [3:0]  byte_en,
    output logic        misaligned
);

    logic [5:0]  opcode_s;
    logic [15:0] imm_s;
    logic [31:0] ea_s;
    store_kind_e kind_s;

    logic        next_we_s;
    logic [3:0]  next_be_s;
    logic [31:0] next_wd_s;
    logic        next_mis_s;

    logic [31:0] address_r;
    logic        write_enable_r;
    logic [31:0] write_data_r;
    logic [3:0]  byte_en_r;
    logic        misaligned_r;

    // Register indices come from the register file upstream; here they are
    // only carried in the instruction word.
    logic        unused_fields_s;

    // Instruction field extraction
    always_comb begin
        opcode_s        = instruction[OPCODE_MSB:OPCODE_LSB];
        imm_s           = instruction[IMM_MSB:IMM_LSB];
        unused_fields_s = ^{instruction[RS_MSB:RS_LSB], instruction[RT_MSB:RT_LSB]};
    end

    store_agu u_agu (
        .base (Read_data1),
        .imm  (imm_s),
        .ea   (ea_s)
    );

    // Lane steering and byte-enable generation for the sampled instruction
    always_comb begin
        kind_s     = decode_kind(opcode_s);
        next_we_s  = 1'b0;
        next_be_s  = 4'b0000;
        next_wd_s  = 32'h0000_0000;
        next_mis_s = 1'b0;

        case (kind_s)
            ST_WORD: begin
                next_we_s = 1'b1;
                next_be_s = 4'b1111;
                next_wd_s = Read_data2;
            end
            ST_HALF: begin
                // Halfword is replicated into both halves; addr[1] picks the half.
                next_we_s = 1'b1;
                next_be_s = ea_s[1] ? 4'b1100 : 4'b0011;
                next_wd_s = {2{Read_data2[15:0]}};
            end
            ST_BYTE: begin
                // Byte is replicated into all lanes; addr[1:0] picks the lane.
                next_we_s = 1'b1;
                next_be_s = 4'b0001 << ea_s[1:0];
                next_wd_s = {4{Read_data2[7:0]}};
            end
            default: begin
                next_we_s  = 1'b0;
                next_be_s  = 4'b0000;
                next_wd_s  = 32'h0000_0000;
                next_mis_s = 1'b0;
            end
        endcase

`ifdef STORE_ALIGN_CHECK_EN
        // A misaligned halfword/word never reaches memory; the address is
        // still registered so the fault handler can see where it pointed.
        if (((kind_s == ST_WORD) && (ea_s[1:0] != 2'b00)) ||
            ((kind_s == ST_HALF) && ea_s[0])) begin
            next_we_s  = 1'b0;
            next_be_s  = 4'b0000;
            next_wd_s  = 32'h0000_0000;
            next_mis_s = 1'b1;
        end else begin
            next_mis_s = 1'b0;
        end
`endif
    end

    // Output registers; reset discards whatever was sampled on that edge
    always_ff @(posedge clk) begin
        if (reset) begin
            address_r      <= 32'h0000_0000;
            write_enable_r <= 1'b0;
            write_data_r   <= 32'h0000_0000;
            byte_en_r      <= 4'b0000;
            misaligned_r   <= 1'b0;
        end else begin
            address_r      <= ea_s;
            write_enable_r <= next_we_s;
            write_data_r   <= next_wd_s;
            byte_en_r      <= next_be_s;
            misaligned_r   <= next_mis_s;
        end
    end

    // Drive ports straight from flops
    always_comb begin
        address      = address_r;
        write_enable = write_enable_r;
        write_data   = write_data_r;
        byte_en      = byte_en_r;
        misaligned   = misaligned_r;
    end

endmodule

// File: tb/tb_store.sv
module tb_store;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] Read_data1;
    logic [31:0] Read_data2;
    logic [31:0] address;
    logic        write_enable;
    logic [31:0] write_data;
    logic [3:0]  byte_en;
    logic        misaligned;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        we;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    store dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .Read_data1   (Read_data1),
        .Read_data2   (Read_data2),
        .address      (address),
        .write_enable (write_enable),
        .write_data   (write_data),
        .byte_en      (byte_en),
        .misaligned   (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] be, input logic we, input logic mis);
        exp_t e;
        e.addr = a; e.wd = wd; e.be = be; e.we = we; e.mis = mis;
        return e;
    endfunction

    // Reference: access size in bytes, lanes [start, start+size) enabled,
    // data byte i taken from store byte (i mod size).
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] d1,
                                   input logic [31:0] d2, input logic rst);
        exp_t        e;
        int          size;
        int          start;
        logic [31:0] a;
        e = '0;
        if (rst) return e;
        a = d1 + 32'($signed(ins[15:0]));
        e.addr = a;
        case (ins[31:26])
            6'b101011: size = 4;
            6'b101001: size = 2;
            6'b101000: size = 1;
            default:   size = 0;
        endcase
        if (size == 0) return e;
`ifdef STORE_ALIGN_CHECK_EN
        if ((a % size) != 0) begin
            e.mis = 1'b1;
            return e;
        end
`endif
        start = int'(a % 4) - int'(a % size);
        for (int i = 0; i < 4; i++) begin
            e.wd[8*i +: 8] = d2[8*(i % size) +: 8];
            e.be[i] = (i >= start) && (i < start + size);
        end
        e.we = 1'b1;
        return e;
    endfunction

    task automatic step(input logic [31:0] ins, input logic [31:0] d1,
                        input logic [31:0] d2, input logic rst, input exp_t e);
        @(negedge clk);
        instruction = ins;
        Read_data1  = d1;
        Read_data2  = d2;
        reset       = rst;
        exp_q.push_back(e);
    endtask

    task automatic step_model(input logic [31:0] ins, input logic [31:0] d1,
                              input logic [31:0] d2, input logic rst);
        step(ins, d1, d2, rst, model(ins, d1, d2, rst));
    endtask

    // Monitor: outputs are presented every cycle; compare against scoreboard
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (address !== e.addr || byte_en !== e.be || write_enable !== e.we ||
                misaligned !== e.mis || (!e.mis && write_data !== e.wd)) begin
                errors++;
                $display("FAIL store_out got addr=%h wd=%h be=%b we=%b mis=%b want addr=%h wd=%h be=%b we=%b mis=%b",
                         address, write_data, byte_en, write_enable, misaligned,
                         e.addr, e.wd, e.be, e.we, e.mis);
            end
        end
    end

    initial begin
        logic [31:0] ins;
        logic [5:0]  op;
        reset       = 1'b1;
        instruction = 32'h0000_0000;
        Read_data1  = 32'h0000_0000;
        Read_data2  = 32'h0000_0000;

        // Reset held two cycles with arbitrary inputs
        step($urandom, $urandom, $urandom, 1'b1, mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
        step(32'hAC890004, 32'h0, 32'h12345678, 1'b1, mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b0));

        // Directed cases, back to back
        step(32'hAC890004, 32'h0, 32'h12345678, 1'b0,
             mk(32'h4, 32'h12345678, 4'hF, 1'b1, 1'b0));
        step(32'hAC8A0020, 32'h1C, 32'hABCDEF01, 1'b0,
             mk(32'h3C, 32'hABCDEF01, 4'hF, 1'b1, 1'b0));
        step(32'hA000FFFF, 32'h10, 32'h55, 1'b0,
             mk(32'hF, 32'h55555555, 4'b1000, 1'b1, 1'b0));
        step(32'hA4000002, 32'h0, 32'h0000BEEF, 1'b0,
             mk(32'h2, 32'hBEEFBEEF, 4'b1100, 1'b1, 1'b0));
`ifdef STORE_ALIGN_CHECK_EN
        step(32'hAC000000, 32'h2, 32'hCAFEF00D, 1'b0,
             mk(32'h2, 32'h0, 4'h0, 1'b0, 1'b1));
        step(32'hA4000001, 32'h0, 32'h1234, 1'b0,
             mk(32'h1, 32'h0, 4'h0, 1'b0, 1'b1));
`else
        step(32'hAC000000, 32'h2, 32'hCAFEF00D, 1'b0,
             mk(32'h2, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0));
        step(32'hA4000001, 32'h0, 32'h1234, 1'b0,
             mk(32'h1, 32'h12341234, 4'b0011, 1'b1, 1'b0));
`endif
        step(32'h8C000010, 32'h100, 32'hFFFFFFFF, 1'b0,
             mk(32'h110, 32'h0, 4'h0, 1'b0, 1'b0));
        // Address wraps modulo 2^32
        step(32'hAC000008, 32'hFFFFFFFC, 32'h1, 1'b0,
             mk(32'h4, 32'h1, 4'hF, 1'b1, 1'b0));
        // Mid-stream reset discards the store sampled on that edge
        step(32'hAC000004, 32'h0, 32'h77, 1'b1, mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
        step(32'hA0000003, 32'h0, 32'hA5, 1'b0,
             mk(32'h3, 32'hA5A5A5A5, 4'b1000, 1'b1, 1'b0));

        // Randomised traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0:       op = 6'b101011;
                1:       op = 6'b101001;
                2:       op = 6'b101000;
                3:       op = 6'b100011;
                default: op = 6'($urandom);
            endcase
            ins = {op, 26'($urandom)};
            step_model(ins, $urandom, $urandom, ($urandom_range(0, 19) == 0));
        end

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store.md
STORE -- requirements
Module: store

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset (clk, reset); no other clock or reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 instruction  input  32  MIPS I-type word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:0] imm.
REQ-005 Read_data1  input  32  register-file value of rs (base).
REQ-006 Read_data2  input  32  register-file value of rt (store data).
REQ-007 address  output  32  registered effective byte address.
REQ-008 write_enable  output  1  registered memory write strobe.
REQ-009 write_data  output  32  registered lane-aligned store data.
REQ-010 byte_en  output  4  registered byte-lane enables; bit i covers data[8i+7:8i].
REQ-011 misaligned  output  1  registered alignment-fault flag.

Function
REQ-012 Effective address SHALL be Read_data1 + sign-extended imm, modulo 2^32, with no overflow detection.
REQ-013 Store opcodes SHALL be: SW 6'b101011, SH 6'b101001, SB 6'b101000; all other opcodes are non-store.
REQ-014 All outputs SHALL be registered on the rising edge of clk, one cycle after instruction/Read_data sampling; the instruction is sampled every cycle with no handshake.
REQ-015 SW: write_data = Read_data2, byte_en = 4'b1111, write_enable = 1.
REQ-016 SH: write_data = {2{Read_data2[15:0]}}; byte_en = 4'b0011 if addr[1]=0, else 4'b1100; write_enable = 1.
REQ-017 SB: write_data = {4{Read_data2[7:0]}}; byte_en = 4'b0001 << addr[1:0]; write_enable = 1.
REQ-018 Little-endian lane mapping SHALL apply throughout.
REQ-019 Non-store opcode: address is still computed and registered; write_enable = 0, byte_en = 0, write_data = 0, misaligned = 0.
REQ-020 Back-to-back stores SHALL each produce one cycle of write_enable with no bubble between them.

Reset
REQ-021 While reset is high at a clock edge, address, write_data, byte_en, write_enable and misaligned SHALL all be 0.
REQ-022 Reset asserted mid-stream SHALL discard the instruction sampled on that edge; normal operation resumes on the first edge with reset low.

Configuration
REQ-023 Macro STORE_ALIGN_CHECK_EN SHALL compile alignment checking in or out.
REQ-024 With the macro defined, SH with addr[0]=1 or SW with addr[1:0]!=0 SHALL force write_enable = 0 and byte_en = 0, set misaligned = 1 for that cycle, and still register address.
REQ-025 Without the macro, misaligned SHALL be tied to 0.
REQ-026 Without the macro, misaligned SH/SW SHALL proceed, using byte_en per REQ-015/016 and ignoring the offending low address bits.

Structure
REQ-027 A shared package store_pkg SHALL hold the opcode constants (OP_SW, OP_SH, OP_SB) and the instruction field bit positions.
REQ-028 Address generation (sign extension plus add) SHALL be a sub-module store_agu; lane and byte-enable generation plus output registers SHALL remain in store.

Verification
REQ-029 Reset held for 2 cycles with any inputs -> all outputs 0.
REQ-030 instruction=32'hAC890004, Read_data1=0, Read_data2=32'h12345678 -> next edge: address=32'h00000004, write_data=32'h12345678, write_enable=1, byte_en=4'hF.
REQ-031 instruction=32'hAC8A0020, Read_data1=32'h1C, Read_data2=32'hABCDEF01 -> address=32'h3C, write_data=32'hABCDEF01, write_enable=1.
REQ-032 SB with imm=16'hFFFF, Read_data1=32'h10, Read_data2=32'h55 -> address=32'hF, byte_en=4'b1000, write_data=32'h55555555.
REQ-033 SW with Read_data1=2, imm=0 -> with STORE_ALIGN_CHECK_EN: write_enable=0, misaligned=1; without: write_enable=1, misaligned=0.
REQ-034 Non-store opcode 6'b100011 -> write_enable=0, byte_en=0, address=rs+imm.
